// File: rtl/cmult_pipe_pkg.sv
// Shared constants and the round/shift/saturate helper for the pipelined complex multiplier.
package cmult_pipe_pkg;

    localparam int DATA_W_DEF     = 12;
    localparam int OUT_W_DEF      = 24;
    localparam int FRAC_SHIFT_DEF = 7;
    localparam int FULL_W_DEF     = 2 * DATA_W_DEF + 1;

    // Working width of the helper; covers FULL_W plus a rounding carry for DATA_W up to 31.
    localparam int ACC_W = 64;

    typedef struct packed {
        logic signed [ACC_W-1:0] value;
        logic                    ovf;
    } sat_t;

    function automatic sat_t sat_round(input logic signed [ACC_W-1:0] sum,
                                       input logic                    rnd,
                                       input int                      frac_shift,
                                       input int                      out_w);
        logic signed [ACC_W-1:0] biased;
        logic signed [ACC_W-1:0] shifted;
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        sat_t                    res;
        biased = sum;
        if (rnd && frac_shift > 0)
            biased = sum + (ACC_W'(1) <<< (frac_shift - 1));
        shifted = biased >>> frac_shift;
        max_v   = (ACC_W'(1) <<< (out_w - 1)) - ACC_W'(1);
        min_v   = -max_v - ACC_W'(1);
        res.ovf = 1'b1;
        if (shifted > max_v)
            res.value = max_v;
        else if (shifted < min_v)
            res.value = min_v;
        else begin
            res.value = shifted;
            res.ovf   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/cmult_pipe_smul.sv
// Registered signed multiplier with clock enable; one of the four S2 product lanes.
module cmult_smul
    import cmult_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       en_i,
    input  logic signed [DATA_W-1:0]   a_i,
    input  logic signed [DATA_W-1:0]   b_i,
    output logic signed [2*DATA_W-1:0] p_o
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] p_q;

    // NOTE: sequential state uses non-blocking assignments; this product register has no
    // reset because the pipeline valid bits decide whether its contents mean anything.
    always_ff @(posedge clk) begin
        if (en_i)
            p_q <= PROD_W'(a_i) * PROD_W'(b_i);
    end

    assign p_o = p_q;

endmodule

// File: rtl/cmult_pipe.sv
// Three-stage complex multiplier: operand register, product register, then sum/round/saturate.
module cmult_pipe
    import cmult_pipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [DATA_W-1:0] c,
    input  logic signed [DATA_W-1:0] d,
    input  logic                     conj,
    input  logic                     rnd,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [OUT_W-1:0]  result_real,
    output logic signed [OUT_W-1:0]  result_img,
    output logic                     ovf,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int FULL_W = 2 * DATA_W + 1;
    localparam int PROD_W = 2 * DATA_W;

    logic                     advance;
    logic signed [DATA_W-1:0] a_q, b_q, c_q, d_q;
    logic                     v1_q, conj1_q, rnd1_q;
    logic                     v2_q, conj2_q, rnd2_q;
    logic signed [PROD_W-1:0] p_ac, p_bd, p_ad, p_bc;
    logic signed [FULL_W-1:0] sum_re, sum_im;
    sat_t                     sat_re, sat_im;
    logic signed [OUT_W-1:0]  re_d, im_d, re_q, im_q;
    logic                     ovf_d, ovf_q, out_valid_q;

    // One enable moves every stage together, so a stalled output freezes the whole pipe.
    assign advance  = rst_n & (~out_valid_q | out_ready);
    assign in_ready = advance;

    always_ff @(posedge clk) begin
        if (advance) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= c;
            d_q     <= d;
            conj1_q <= conj;
            rnd1_q  <= rnd;
            conj2_q <= conj1_q;
            rnd2_q  <= rnd1_q;
        end
    end

    cmult_smul #(.DATA_W(DATA_W)) u_ac (.clk(clk), .en_i(advance), .a_i(a_q), .b_i(c_q), .p_o(p_ac));
    cmult_smul #(.DATA_W(DATA_W)) u_bd (.clk(clk), .en_i(advance), .a_i(b_q), .b_i(d_q), .p_o(p_bd));
    cmult_smul #(.DATA_W(DATA_W)) u_ad (.clk(clk), .en_i(advance), .a_i(a_q), .b_i(d_q), .p_o(p_ad));
    cmult_smul #(.DATA_W(DATA_W)) u_bc (.clk(clk), .en_i(advance), .a_i(b_q), .b_i(c_q), .p_o(p_bc));

    // NOTE: combinational logic uses blocking assignments and gives every output a value
    // on every path, so no latch is inferred.
    always_comb begin
        if (conj2_q) begin
            sum_re = FULL_W'(p_ac) + FULL_W'(p_bd);
            sum_im = FULL_W'(p_bc) - FULL_W'(p_ad);
        end else begin
            sum_re = FULL_W'(p_ac) - FULL_W'(p_bd);
            sum_im = FULL_W'(p_ad) + FULL_W'(p_bc);
        end
        sat_re = sat_round(ACC_W'(sum_re), rnd2_q, FRAC_SHIFT, OUT_W);
        sat_im = sat_round(ACC_W'(sum_im), rnd2_q, FRAC_SHIFT, OUT_W);
        re_d   = OUT_W'(sat_re.value);
        im_d   = OUT_W'(sat_im.value);
        ovf_d  = sat_re.ovf | sat_im.ovf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            re_q        <= '0;
            im_q        <= '0;
            ovf_q       <= 1'b0;
        end else if (advance) begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            // Bubbles leave the last delivered result in place.
            if (v2_q) begin
                re_q  <= re_d;
                im_q  <= im_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign result_real = re_q;
    assign result_img  = im_q;
    assign ovf         = ovf_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_cmult_pipe.sv
// Scoreboard bench for cmult_pipe (DATA_W=12, OUT_W=12, FRAC_SHIFT=7) with directed vectors.
module tb_cmult_pipe;

    localparam int DW = 12;
    localparam int OW = 12;
    localparam int FS = 7;

    typedef struct {
        int a, b, c, d;
        bit conj, rnd;
        int re, im;
        bit ovf;
    } vec_t;

    typedef struct {
        int id;
        int re, im;
        bit ovf;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic signed [DW-1:0] a, b, c, d;
    logic                 conj, rnd, in_valid, in_ready;
    logic signed [OW-1:0] result_real, result_img;
    logic                 ovf, out_valid, out_ready;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   stall_cnt = 0;
    exp_t sb_q[$];

    // Hand-computed expectations, OUT_W=12, shift 7.
    // +2048 does not fit in 12 bits, so the positive-saturation case uses conj=1 with d=-2048,
    // which yields the same sums as conj=0 with d=+2048.
    vec_t vecs[10] = '{
        '{  128,     0,    64,   -64, 1'b0, 1'b0,    64,   -64, 1'b0},
        '{  128,     0,    64,   -64, 1'b1, 1'b0,    64,    64, 1'b0},
        '{    1,     0,    64,     0, 1'b0, 1'b0,     0,     0, 1'b0},
        '{    1,     0,    64,     0, 1'b0, 1'b1,     1,     0, 1'b0},
        '{    1,     0,   -64,     0, 1'b0, 1'b0,    -1,     0, 1'b0},
        '{    1,     0,   -64,     0, 1'b0, 1'b1,     0,     0, 1'b0},
        '{-2048, -2048, -2048, -2048, 1'b1, 1'b0,  2047,     0, 1'b1},
        '{-2048, -2048, -2048, -2048, 1'b0, 1'b0,     0,  2047, 1'b1},
        '{-2048,     0,  2047,     0, 1'b0, 1'b0, -2048,     0, 1'b1},
        '{    3,    -5,   100,   -20, 1'b0, 1'b1,     2,    -4, 1'b0}
    };

    cmult_pipe #(.DATA_W(DW), .OUT_W(OW), .FRAC_SHIFT(FS)) dut (
        .clk(clk), .rst_n(rst_n),
        .a(a), .b(b), .c(c), .d(d),
        .conj(conj), .rnd(rnd),
        .in_valid(in_valid), .in_ready(in_ready),
        .result_real(result_real), .result_img(result_img),
        .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present one vector and hold it until accepted; the expectation is queued at acceptance.
    task automatic send(input vec_t v, input int id);
        int   waited = 0;
        exp_t e;
        a = DW'(v.a); b = DW'(v.b); c = DW'(v.c); d = DW'(v.d);
        conj = v.conj; rnd = v.rnd; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout v%0d: in_ready stayed 0 for %0d cycles", id, waited);
            in_valid = 1'b0;
            return;
        end
        e.id = id; e.re = v.re; e.im = v.im; e.ovf = v.ovf;
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int waited = 0;
        while (sb_q.size() != 0 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        repeat (2) @(posedge clk);
        #1;
        check(name, sb_q.size(), 0);
    endtask

    // Monitor: compares on every transfer, and checks outputs hold while stalled.
    logic                 stalled_prev = 1'b0;
    logic signed [OW-1:0] held_re, held_im;
    logic                 held_ovf;

    always @(negedge clk) begin
        exp_t e;
        if (stalled_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_real", result_real, held_re);
            check("hold_img", result_img, held_im);
            check("hold_ovf", ovf, held_ovf);
        end
        stalled_prev = 1'b0;
        if (out_valid === 1'b1) begin
            if (out_ready === 1'b0) begin
                check("stall_in_ready", in_ready, 0);
                stall_cnt++;
                stalled_prev = 1'b1;
                held_re  = result_real;
                held_im  = result_img;
                held_ovf = ovf;
            end else if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got real=%0d img=%0d, expected no output",
                         result_real, result_img);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("v%0d_real", e.id), result_real, e.re);
                check($sformatf("v%0d_img", e.id), result_img, e.im);
                check($sformatf("v%0d_ovf", e.id), ovf, e.ovf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; d = '0; conj = 1'b0; rnd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_real", result_real, 0);
        check("rst_img", result_img, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: out_valid rises after the third edge counting the accepting one.
        send(vecs[0], 0);
        check("lat_edge1", out_valid, 0);
        @(posedge clk); #1;
        check("lat_edge2", out_valid, 0);
        @(posedge clk); #1;
        check("lat_edge3", out_valid, 1);

        for (int i = 1; i < 10; i++) send(vecs[i], i);
        drain("drain_directed");

        // Back-to-back stream with a 4-cycle consumer stall in the middle.
        stall_cnt = 0;
        fork
            begin
                for (int k = 1; k <= 6; k++) begin
                    v = '{128 * k, -128, 64, 0, 1'b0, 1'b0, 64 * k, -64, 1'b0};
                    send(v, 100 + k);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("drain_stream");
        check("stall_cycles", stall_cnt, 4);

        // Reset with two operations in flight; neither may ever appear.
        v = '{256, 0, 64, 0, 1'b0, 1'b0, 128, 0, 1'b0};
        send(v, 200);
        send(v, 201);
        rst_n = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_real", result_real, 0);
        check("midrst_img", result_img, 0);
        check("midrst_ovf", ovf, 0);
        check("midrst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        send(vecs[9], 300);
        drain("drain_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
